// File: rtl/mdio_responder.sv
// MDIO (clause 22) management-frame responder, oversampling MDC in the clk domain.
// Optional build macro MDIO_ADDR_FILTER_EN: silently skip frames whose PHYAD != PHY_ADDR.
module mdio_responder #(
  parameter logic [4:0] PHY_ADDR = 5'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MDC,
  input  logic        MDIO_OUT,
  input  logic        MDIO_OE,
  output logic        MDIO_RSP,
  output logic        MDIO_RSP_OE,
  output logic [4:0]  ADDR,
  output logic [15:0] WR_DATA,
  output logic        WR_STB,
  output logic        RD_REQ,
  input  logic [15:0] RD_DATA,
  output logic        FRAME_ERR
);

  typedef enum logic [2:0] {
    IDLE, ST, OP, ADDRS, TA, WDATA, RDATA, SKIP
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        mdc_q;
  logic [15:0] shift_q, shift_d;
  logic [15:0] rdShift_q, rdShift_d;
  logic        opRead_q, opRead_d;
  logic        rdLat_q;
  logic        rsp_q, rsp_d;
  logic        rspOe_q, rspOe_d;
  logic [4:0]  addr_q, addr_d;
  logic [15:0] wrData_q, wrData_d;
  logic        wrStb_q, wrStb_d;
  logic        rdReq_q, rdReq_d;
  logic        frameErr_q, frameErr_d;

  logic        rise, fall;
  logic [4:0]  cntInc;
  logic [1:0]  twoBits;
  logic        phyHit;
  logic        phyMatch;

  assign rise    = MDC & ~mdc_q;
  assign fall    = ~MDC & mdc_q;
  assign cntInc  = cnt_q + 5'd1;
  assign twoBits = {shift_q[0], MDIO_OUT};
  assign phyHit  = (shift_q[8:4] == PHY_ADDR);

`ifdef MDIO_ADDR_FILTER_EN
  assign phyMatch = phyHit;
`else
  // Without the filter every PHYAD is answered; the compare folds away.
  assign phyMatch = phyHit | 1'b1;
`endif

  // cnt_q holds the index of the last frame bit received, so a rise with
  // cnt_q == N delivers frame bit N+1 (0-based, MSB first).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rdShift_d  = rdLat_q ? RD_DATA : rdShift_q;
    opRead_d   = opRead_q;
    rsp_d      = rsp_q;
    rspOe_d    = rspOe_q;
    addr_d     = addr_q;
    wrData_d   = wrData_q;
    wrStb_d    = 1'b0;
    rdReq_d    = 1'b0;
    frameErr_d = 1'b0;

    if (rise) begin
      shift_d = {shift_q[14:0], MDIO_OUT};
    end

    case (state_q)
      IDLE: begin
        cnt_d = 5'd0;
        if (rise && MDIO_OE && !MDIO_OUT) begin
          state_d = ST;
        end
      end

      ST: begin
        if (!MDIO_OE) begin
          frameErr_d = 1'b1;
          state_d    = IDLE;
        end else if (rise) begin
          if (MDIO_OUT) begin
            cnt_d   = 5'd1;
            state_d = OP;
          end else begin
            frameErr_d = 1'b1;
            state_d    = IDLE;
          end
        end
      end

      OP: begin
        if (!MDIO_OE) begin
          frameErr_d = 1'b1;
          state_d    = IDLE;
        end else if (rise) begin
          cnt_d = cntInc;
          if (cnt_q == 5'd2) begin
            case (twoBits)
              2'b01: begin
                opRead_d = 1'b0;
                state_d  = ADDRS;
              end
              2'b10: begin
                opRead_d = 1'b1;
                state_d  = ADDRS;
              end
              default: begin
                frameErr_d = 1'b1;
                state_d    = SKIP;
              end
            endcase
          end
        end
      end

      ADDRS: begin
        if (!MDIO_OE) begin
          frameErr_d = 1'b1;
          state_d    = IDLE;
        end else if (rise) begin
          cnt_d = cntInc;
          if (cnt_q == 5'd12) begin
            addr_d = {shift_q[3:0], MDIO_OUT};
            if (!phyMatch) begin
              state_d = SKIP;
            end else if (opRead_q) begin
              rdReq_d = 1'b1;
              state_d = RDATA;
            end else begin
              state_d = TA;
            end
          end
        end
      end

      TA: begin
        if (rise) begin
          cnt_d = cntInc;
          if (cnt_q == 5'd14) begin
            if (twoBits == 2'b10) begin
              state_d = WDATA;
            end else begin
              frameErr_d = 1'b1;
              state_d    = SKIP;
            end
          end
        end
      end

      WDATA: begin
        if (!MDIO_OE) begin
          frameErr_d = 1'b1;
          state_d    = IDLE;
        end else if (rise) begin
          cnt_d = cntInc;
          if (cnt_q == 5'd30) begin
            wrData_d = {shift_q[14:0], MDIO_OUT};
            wrStb_d  = 1'b1;
            state_d  = IDLE;
          end
        end
      end

      RDATA: begin
        if (rise) begin
          cnt_d = cntInc;
        end
        // Falls after rise 15 (TA zero), rises 16..31 (data), rise 32 (release).
        if (fall) begin
          if (cnt_q == 5'd14) begin
            rspOe_d = 1'b1;
            rsp_d   = 1'b0;
          end else if (cnt_q == 5'd31) begin
            rspOe_d = 1'b0;
            rsp_d   = 1'b0;
            state_d = IDLE;
          end else if (cnt_q >= 5'd15) begin
            rsp_d     = rdShift_q[15];
            rdShift_d = {rdShift_q[14:0], 1'b0};
          end
        end
      end

      SKIP: begin
        if (rise) begin
          cnt_d = cntInc;
          if (cnt_q == 5'd30) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      mdc_q      <= MDC;
      shift_q    <= 16'd0;
      rdShift_q  <= 16'd0;
      opRead_q   <= 1'b0;
      rdLat_q    <= 1'b0;
      rsp_q      <= 1'b0;
      rspOe_q    <= 1'b0;
      addr_q     <= 5'd0;
      wrData_q   <= 16'd0;
      wrStb_q    <= 1'b0;
      rdReq_q    <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mdc_q      <= MDC;
      shift_q    <= shift_d;
      rdShift_q  <= rdShift_d;
      opRead_q   <= opRead_d;
      rdLat_q    <= rdReq_q;
      rsp_q      <= rsp_d;
      rspOe_q    <= rspOe_d;
      addr_q     <= addr_d;
      wrData_q   <= wrData_d;
      wrStb_q    <= wrStb_d;
      rdReq_q    <= rdReq_d;
      frameErr_q <= frameErr_d;
    end
  end

  assign MDIO_RSP    = rsp_q;
  assign MDIO_RSP_OE = rspOe_q;
  assign ADDR        = addr_q;
  assign WR_DATA     = wrData_q;
  assign WR_STB      = wrStb_q;
  assign RD_REQ      = rdReq_q;
  assign FRAME_ERR   = frameErr_q;

endmodule

// File: tb/tb_mdio_responder.sv
// Directed bench for mdio_responder: write, read, malformed frames, OE drop, reset abort, PHYAD filter.
module tb_mdio_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        MDC;
  logic        MDIO_OUT;
  logic        MDIO_OE;
  logic        MDIO_RSP;
  logic        MDIO_RSP_OE;
  logic [4:0]  ADDR;
  logic [15:0] WR_DATA;
  logic        WR_STB;
  logic        RD_REQ;
  logic [15:0] RD_DATA;
  logic        FRAME_ERR;

  int vectors     = 0;
  int miscompares = 0;

  mdio_responder #(.PHY_ADDR(5'd0)) dut (
    .clk         (clk),
    .rst         (rst),
    .MDC         (MDC),
    .MDIO_OUT    (MDIO_OUT),
    .MDIO_OE     (MDIO_OE),
    .MDIO_RSP    (MDIO_RSP),
    .MDIO_RSP_OE (MDIO_RSP_OE),
    .ADDR        (ADDR),
    .WR_DATA     (WR_DATA),
    .WR_STB      (WR_STB),
    .RD_REQ      (RD_REQ),
    .RD_DATA     (RD_DATA),
    .FRAME_ERR   (FRAME_ERR)
  );

  always #5 clk = ~clk;

  // Register file model: contents are only valid the cycle after RD_REQ.
  logic [15:0] rdDataReg = 16'h0000;
  always @(posedge clk) rdDataReg <= RD_REQ ? 16'hBEEF : 16'h0000;
  assign RD_DATA = rdDataReg;

  // Pulse monitors, sampled mid-cycle.
  int          wrStbCount    = 0;
  int          rdReqCount    = 0;
  int          frameErrCount = 0;
  logic [15:0] lastWrData    = 16'h0000;
  logic [4:0]  lastWrAddr    = 5'd0;
  always @(negedge clk) begin
    if (WR_STB === 1'b1) begin
      wrStbCount++;
      lastWrData = WR_DATA;
      lastWrAddr = ADDR;
    end
    if (RD_REQ === 1'b1) rdReqCount++;
    if (FRAME_ERR === 1'b1) frameErrCount++;
  end

  logic        rspOeLog [0:32];
  logic        rspLog   [0:32];
  logic [25:0] rstSnapshot;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Shifts nBits of frame MSB first; controller drives only the first oeBits.
  // rstAt >= 0 pulls rst low at that bit slot and abandons the frame.
  task automatic applyStimulus(input logic [31:0] frame, input int nBits, input int oeBits, input int rstAt);
    for (int i = 0; i < 33; i++) begin
      rspOeLog[i] = 1'b0;
      rspLog[i]   = 1'b0;
    end
    for (int i = 0; i < nBits; i++) begin
      if (i == rstAt) begin
        @(negedge clk);
        rst     = 1'b0;
        MDIO_OE = 1'b0;
        @(negedge clk);
        rstSnapshot = {MDIO_RSP, MDIO_RSP_OE, ADDR, WR_DATA, WR_STB, RD_REQ, FRAME_ERR};
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        return;
      end
      @(negedge clk);
      MDIO_OE  = (i < oeBits);
      MDIO_OUT = (i < oeBits) ? frame[31 - i] : 1'b1;
      repeat (3) @(negedge clk);
      rspOeLog[i] = MDIO_RSP_OE;
      rspLog[i]   = MDIO_RSP;
      @(negedge clk);
      MDC = 1'b1;
      repeat (4) @(negedge clk);
      MDC = 1'b0;
    end
    @(negedge clk);
    MDIO_OE  = 1'b0;
    MDIO_OUT = 1'b1;
    repeat (3) @(negedge clk);
    rspOeLog[32] = MDIO_RSP_OE;
    rspLog[32]   = MDIO_RSP;
    repeat (6) @(negedge clk);
  endtask

  int          baseWr, baseRd, baseErr;
  int          oeSlots;
  logic [16:0] rspSeq;

  initial begin
    rst      = 1'b0;
    MDC      = 1'b0;
    MDIO_OUT = 1'b1;
    MDIO_OE  = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_rsp",    {31'd0, MDIO_RSP},    32'd0);
    checkOutput("rst_rsp_oe", {31'd0, MDIO_RSP_OE}, 32'd0);
    checkOutput("rst_addr",   {27'd0, ADDR},        32'd0);
    checkOutput("rst_wrdata", {16'd0, WR_DATA},     32'd0);
    checkOutput("rst_strobes", {29'd0, WR_STB, RD_REQ, FRAME_ERR}, 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] write 0x50161234");
    baseWr = wrStbCount; baseRd = rdReqCount; baseErr = frameErrCount;
    applyStimulus(32'h5016_1234, 32, 32, -1);
    checkOutput("wr_stb_count", wrStbCount - baseWr, 32'd1);
    checkOutput("wr_addr",      {27'd0, lastWrAddr}, 32'h05);
    checkOutput("wr_data",      {16'd0, lastWrData}, 32'h1234);
    checkOutput("wr_frame_err", frameErrCount - baseErr, 32'd0);
    checkOutput("wr_rd_req",    rdReqCount - baseRd, 32'd0);

    $display("[TB] read 0x6016, RD_DATA=BEEF");
    baseWr = wrStbCount; baseRd = rdReqCount; baseErr = frameErrCount;
    applyStimulus(32'h6016_0000, 32, 14, -1);
    oeSlots = 0;
    rspSeq  = 17'd0;
    for (int i = 0; i < 32; i++) begin
      if (rspOeLog[i] === 1'b1) oeSlots++;
    end
    for (int i = 15; i < 32; i++) rspSeq = {rspSeq[15:0], rspLog[i]};
    checkOutput("rd_req_count", rdReqCount - baseRd, 32'd1);
    checkOutput("rd_addr",      {27'd0, ADDR}, 32'h05);
    checkOutput("rd_oe_before", {31'd0, rspOeLog[14]}, 32'd0);
    checkOutput("rd_oe_slots",  oeSlots, 32'd17);
    checkOutput("rd_rsp_seq",   {15'd0, rspSeq}, 32'h0_BEEF);
    checkOutput("rd_oe_release", {31'd0, rspOeLog[32]}, 32'd0);
    checkOutput("rd_frame_err", frameErrCount - baseErr, 32'd0);
    checkOutput("rd_wr_stb",    wrStbCount - baseWr, 32'd0);

    $display("[TB] bad start bits 1,0,0");
    baseWr = wrStbCount; baseRd = rdReqCount; baseErr = frameErrCount;
    applyStimulus(32'h8000_0000, 3, 3, -1);
    checkOutput("st_frame_err", frameErrCount - baseErr, 32'd1);
    checkOutput("st_no_strobe", (wrStbCount - baseWr) + (rdReqCount - baseRd), 32'd0);

    $display("[TB] bad opcode 11");
    baseWr = wrStbCount; baseRd = rdReqCount; baseErr = frameErrCount;
    applyStimulus(32'h7016_1234, 32, 32, -1);
    checkOutput("op_frame_err", frameErrCount - baseErr, 32'd1);
    checkOutput("op_no_strobe", (wrStbCount - baseWr) + (rdReqCount - baseRd), 32'd0);
    checkOutput("op_rsp_oe",    {31'd0, MDIO_RSP_OE}, 32'd0);

    $display("[TB] write after errors");
    baseWr = wrStbCount; baseErr = frameErrCount;
    applyStimulus(32'h5016_5A5A, 32, 32, -1);
    checkOutput("recover_wr_stb",  wrStbCount - baseWr, 32'd1);
    checkOutput("recover_wr_data", {16'd0, lastWrData}, 32'h5A5A);
    checkOutput("recover_err",     frameErrCount - baseErr, 32'd0);

    $display("[TB] OE drop after 20 write bits");
    baseWr = wrStbCount; baseErr = frameErrCount;
    applyStimulus(32'h5016_1234, 32, 20, -1);
    checkOutput("oedrop_frame_err", frameErrCount - baseErr, 32'd1);
    checkOutput("oedrop_wr_stb",    wrStbCount - baseWr, 32'd0);

    $display("[TB] reset at read bit 24");
    baseWr = wrStbCount; baseErr = frameErrCount;
    applyStimulus(32'h6016_0000, 32, 14, 24);
    checkOutput("rstmid_oe_before", {31'd0, rspOeLog[23]}, 32'd1);
    checkOutput("rstmid_outputs",   {6'd0, rstSnapshot}, 32'd0);
    checkOutput("rstmid_frame_err", frameErrCount - baseErr, 32'd0);
    checkOutput("rstmid_wr_stb",    wrStbCount - baseWr, 32'd0);
    baseWr = wrStbCount;
    applyStimulus(32'h5016_ABCD, 32, 32, -1);
    checkOutput("rstmid_next_stb",  wrStbCount - baseWr, 32'd1);
    checkOutput("rstmid_next_data", {16'd0, lastWrData}, 32'hABCD);

    $display("[TB] write to PHYAD 3");
    baseWr = wrStbCount; baseErr = frameErrCount;
    applyStimulus(32'h5196_0055, 32, 32, -1);
    checkOutput("phy_frame_err", frameErrCount - baseErr, 32'd0);
`ifdef MDIO_ADDR_FILTER_EN
    checkOutput("phy_filtered_stb", wrStbCount - baseWr, 32'd0);
`else
    checkOutput("phy_open_stb",  wrStbCount - baseWr, 32'd1);
    checkOutput("phy_open_data", {16'd0, lastWrData}, 32'h0055);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mdio_responder.md
MDIO_RESPONDER -- requirements
Module: mdio_responder

Interface
REQ-001 SHALL have parameter PHY_ADDR, default 5'd0: the management address this responder answers to.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port MDC, input, 1 bit: management clock from the controller, sampled as data in the clk domain.
REQ-005 SHALL have port MDIO_OUT, input, 1 bit: serial data driven by the controller.
REQ-006 SHALL have port MDIO_OE, input, 1 bit: high while the controller drives MDIO_OUT.
REQ-007 SHALL have port MDIO_RSP, output, 1 bit: serial read data back to the controller.
REQ-008 SHALL have port MDIO_RSP_OE, output, 1 bit: high while the responder drives MDIO_RSP.
REQ-009 SHALL have port ADDR, output, 5 bits: register address (REGAD) of the current or last frame.
REQ-010 SHALL have port WR_DATA, output, 16 bits: data captured from a write frame.
REQ-011 SHALL have port WR_STB, output, 1 bit: one-clk pulse when WR_DATA/ADDR hold a completed write.
REQ-012 SHALL have port RD_REQ, output, 1 bit: one-clk pulse requesting RD_DATA for ADDR.
REQ-013 SHALL have port RD_DATA, input, 16 bits: register contents, valid the clk cycle after RD_REQ.
REQ-014 SHALL have port FRAME_ERR, output, 1 bit: one-clk pulse on a malformed or aborted frame.

Function
REQ-015 SHALL detect MDC edges from a registered copy: rise = MDC & ~mdc_q, fall = ~MDC & mdc_q; frame bits are sampled only on rise.
REQ-016 SHALL use the frame format, MSB first, 32 bits: ST[31:30]=01, OP[29:28] (01 write, 10 read), PHYAD[27:23], REGAD[22:18], TA[17:16], DATA[15:0].
REQ-017 SHALL use states IDLE, ST, OP, ADDRS, TA, WDATA, RDATA, SKIP, plus a 5-bit bit counter.
REQ-018 SHALL, in IDLE, move to ST on a rise with MDIO_OE=1 and MDIO_OUT=0.
REQ-019 SHALL, in ST, move to OP if the next sampled bit is 1; otherwise pulse FRAME_ERR and return to IDLE.
REQ-020 SHALL, in OP, treat OP=00 or 11 as invalid: pulse FRAME_ERR and go to SKIP.
REQ-021 SHALL, in ADDRS, shift 10 bits; ADDR updates after the 14th frame bit.
REQ-022 SHALL, for a read, pulse RD_REQ in the clk cycle after the 14th rise and latch RD_DATA one clk later.
REQ-023 SHALL, for a write, check TA for the pattern 10 and go to WDATA; any other pattern pulses FRAME_ERR and goes to SKIP.
REQ-024 SHALL, in WDATA, after the 32nd rise, load WR_DATA, pulse WR_STB for exactly one clk, and go to IDLE.
REQ-025 SHALL, for a read, assert MDIO_RSP_OE on the fall after the 15th rise and drive MDIO_RSP=0 (second TA bit).
REQ-026 SHALL then drive DATA[15] down to DATA[0], updating on each subsequent fall.
REQ-027 SHALL deassert MDIO_RSP_OE and MDIO_RSP on the fall after the 32nd rise, then go to IDLE.
REQ-028 SHALL, if MDIO_OE drops during ST, OP, ADDRS or WDATA, pulse FRAME_ERR, suppress WR_STB, and go to IDLE.
REQ-029 SHALL, in SKIP, count rises to 32 total frame bits and then go to IDLE with no outputs driven.
REQ-030 SHALL treat rise and fall as never coincident; an MDC period of at least 4 clk cycles is required.

Reset
REQ-031 SHALL, on rst=0 at a clk edge, clear all outputs (MDIO_RSP, MDIO_RSP_OE, ADDR, WR_DATA, WR_STB, RD_REQ, FRAME_ERR) to 0.
REQ-032 SHALL, on rst=0, set the state to IDLE, clear the bit counter, and load mdc_q with the current MDC (no spurious edge).
REQ-033 SHALL, on reset mid-frame, abort the frame: no WR_STB, no FRAME_ERR, and MDIO_RSP_OE low by the next clk.

Configuration
REQ-034 SHALL, with MDIO_ADDR_FILTER_EN defined, go to SKIP silently (no RD_REQ, WR_STB, FRAME_ERR or MDIO_RSP_OE) when PHYAD != PHY_ADDR.
REQ-035 SHALL, without MDIO_ADDR_FILTER_EN, ignore PHYAD and answer every valid frame.

Verification
REQ-036 Write frame 0x50161234 -> one WR_STB pulse with ADDR=5'h05, WR_DATA=16'h1234, FRAME_ERR=0.
REQ-037 Read header 0x6016, controller drops OE at TA, RD_DATA=16'hBEEF -> RD_REQ once; MDIO_RSP_OE high for 17 bit slots; MDIO_RSP sequence 0 followed by BEEF MSB first.
REQ-038 Frame with ST=10 (first bits 1,0 after 0) and frame with OP=11 -> FRAME_ERR pulse, no WR_STB or RD_REQ, and the next valid write is accepted.
REQ-039 MDIO_OE drops after 20 bits of write 0x50161234 -> FRAME_ERR pulse, WR_STB stays 0.
REQ-040 rst=0 asserted at read bit 24 -> MDIO_RSP_OE=0 next clk, all outputs 0; a following write 0x5016ABCD gives WR_DATA=16'hABCD.
REQ-041 Write 0x5196_0055 (PHYAD=3, PHY_ADDR=0) -> with MDIO_ADDR_FILTER_EN: no WR_STB; without it: WR_STB with WR_DATA=16'h0055.
